// File: rtl/mem_skew.sv
// rtl/mem_skew.sv - per-column skew/deskew delay line with valid tracking, flush and mode guard.
// Optional build macro MEM_SKEW_ZERO_FILL_EN forces Bout[c] to 0 while out_valid[c] is low.
module mem_skew #(
  parameter int BITS = 32,
  parameter int DIM  = 8,
  parameter int BASE = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       in_valid,
  input  logic [DIM-1:0][BITS-1:0]   Bin,
  input  logic                       mode,
  input  logic                       flush,
  output logic [DIM-1:0][BITS-1:0]   Bout,
  output logic [DIM-1:0]             out_valid,
  output logic                       busy,
  output logic                       mode_q
);

  localparam int LEN = BASE + DIM - 1;

  logic [BITS-1:0] r_data  [DIM][LEN];
  logic [LEN-1:0]  r_valid [DIM];
  logic            r_mode_q;
  logic            w_busy;
  logic            w_mode_eff;

  always_comb begin
    w_busy = 1'b0;
    for (int c = 0; c < DIM; c++) begin
      w_busy = w_busy | (|r_valid[c]);
    end
  end

  // A mode request only takes effect once every column has drained.
  assign w_mode_eff = w_busy ? r_mode_q : mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode_q <= 1'b0;
      for (int c = 0; c < DIM; c++) begin
        r_valid[c] <= '0;
        for (int s = 0; s < LEN; s++) begin
          r_data[c][s] <= '0;
        end
      end
    end else begin
      r_mode_q <= w_mode_eff;
      for (int c = 0; c < DIM; c++) begin
        if (flush) begin
          r_valid[c] <= '0;
        end else if (en) begin
          r_valid[c] <= {r_valid[c][LEN-2:0], in_valid};
          r_data[c][0] <= Bin[c];
          for (int s = 1; s < LEN; s++) begin
            r_data[c][s] <= r_data[c][s-1];
          end
        end
      end
    end
  end

  // Tap stage D(c)-1; both candidate taps are constants per column.
  for (genvar g = 0; g < DIM; g++) begin : g_tap
    localparam int TAP_SKEW   = BASE + g - 1;
    localparam int TAP_DESKEW = BASE + DIM - 2 - g;
    logic [BITS-1:0] w_data;
    logic            w_vld;

    assign w_data         = r_mode_q ? r_data[g][TAP_DESKEW]  : r_data[g][TAP_SKEW];
    assign w_vld          = r_mode_q ? r_valid[g][TAP_DESKEW] : r_valid[g][TAP_SKEW];
    assign out_valid[g]   = w_vld;
`ifdef MEM_SKEW_ZERO_FILL_EN
    assign Bout[g]        = w_vld ? w_data : '0;
`else
    assign Bout[g]        = w_data;
`endif
  end

  assign busy   = w_busy;
  assign mode_q = r_mode_q;

endmodule

// File: tb/tb_mem_skew.sv
// tb/tb_mem_skew.sv - table-driven self-checking bench for mem_skew (DIM=4, BASE=4, BITS=32).
module tb_mem_skew;
  localparam int BITS = 32;
  localparam int DIM  = 4;
  localparam int BASE = 4;

  logic                     clk = 1'b0;
  logic                     rst, en, in_valid, mode, flush;
  logic [DIM-1:0][BITS-1:0] Bin, Bout;
  logic [DIM-1:0]           out_valid;
  logic                     busy, mode_q;

  always #5 clk = ~clk;

  mem_skew #(.BITS(BITS), .DIM(DIM), .BASE(BASE)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .Bin(Bin),
    .mode(mode), .flush(flush), .Bout(Bout), .out_valid(out_valid),
    .busy(busy), .mode_q(mode_q)
  );

  typedef struct {
    logic       rst, en, iv, mode, flush;
    logic [7:0] bin;
    logic [3:0] ov;
    logic       bz, mq;
    logic [3:0] bmask;
    logic [7:0] bexp;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic r, e, iv, m, f, input logic [7:0] b,
                     input logic [3:0] ov, input logic bz, mq,
                     input logic [3:0] bm, input logic [7:0] bx);
    vec_t v;
    v.rst = r; v.en = e; v.iv = iv; v.mode = m; v.flush = f; v.bin = b;
    v.ov = ov; v.bz = bz; v.mq = mq; v.bmask = bm; v.bexp = bx;
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, e, iv, m, f, input logic [7:0] b);
    rst = r; en = e; in_valid = iv; mode = m; flush = f;
    for (int c = 0; c < DIM; c++) Bin[c] = 32'(b) + 32'(c);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  function automatic logic [31:0] ev(input logic [7:0] bx, input int c);
    return (bx == 8'h00) ? 32'h0 : 32'(bx) + 32'(c);
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; mode = 1'b0; flush = 1'b0; Bin = '0;

    //  rst en iv md fl  bin    ov    bz mq  bmask bexp
    add(1, 0, 0, 0, 0, 8'h00, 4'h0, 0, 0, 4'hf, 8'h00);
    // skew
    add(0, 1, 1, 0, 0, 8'hA0, 4'h0, 1, 0, 4'h0, 8'h00);
    add(0, 1, 0, 0, 0, 8'h55, 4'h0, 1, 0, 4'h0, 8'h00);
    add(0, 1, 0, 0, 0, 8'h55, 4'h0, 1, 0, 4'h0, 8'h00);
    add(0, 1, 0, 0, 0, 8'h55, 4'h1, 1, 0, 4'h1, 8'hA0);
    add(0, 1, 0, 0, 0, 8'h55, 4'h2, 1, 0, 4'h2, 8'hA0);
    add(0, 1, 0, 0, 0, 8'h55, 4'h4, 1, 0, 4'h4, 8'hA0);
    add(0, 1, 0, 0, 0, 8'h55, 4'h8, 1, 0, 4'h8, 8'hA0);
    add(0, 1, 0, 0, 0, 8'h55, 4'h0, 0, 0, 4'h0, 8'h00);
    // deskew
    add(0, 1, 1, 1, 0, 8'hA0, 4'h0, 1, 1, 4'h0, 8'h00);
    add(0, 1, 0, 1, 0, 8'h55, 4'h0, 1, 1, 4'h0, 8'h00);
    add(0, 1, 0, 1, 0, 8'h55, 4'h0, 1, 1, 4'h0, 8'h00);
    add(0, 1, 0, 1, 0, 8'h55, 4'h8, 1, 1, 4'h8, 8'hA0);
    add(0, 1, 0, 1, 0, 8'h55, 4'h4, 1, 1, 4'h4, 8'hA0);
    add(0, 1, 0, 1, 0, 8'h55, 4'h2, 1, 1, 4'h2, 8'hA0);
    add(0, 1, 0, 1, 0, 8'h55, 4'h1, 1, 1, 4'h1, 8'hA0);
    add(0, 1, 0, 1, 0, 8'h55, 4'h0, 0, 1, 4'h0, 8'h00);
    // mode guard: new mode applies to the accepted word, later toggles ignored while busy
    add(0, 1, 1, 0, 0, 8'hB0, 4'h0, 1, 0, 4'h0, 8'h00);
    add(0, 1, 0, 1, 0, 8'h55, 4'h0, 1, 0, 4'h0, 8'h00);
    add(0, 1, 0, 1, 0, 8'h55, 4'h0, 1, 0, 4'h0, 8'h00);
    add(0, 1, 0, 1, 0, 8'h55, 4'h1, 1, 0, 4'h1, 8'hB0);
    add(0, 1, 0, 1, 0, 8'h55, 4'h2, 1, 0, 4'h2, 8'hB0);
    add(0, 1, 0, 1, 0, 8'h55, 4'h4, 1, 0, 4'h4, 8'hB0);
    add(0, 1, 0, 1, 0, 8'h55, 4'h8, 1, 0, 4'h8, 8'hB0);
    add(0, 1, 0, 1, 0, 8'h55, 4'h0, 0, 0, 4'h0, 8'h00);
    add(0, 1, 0, 1, 0, 8'h55, 4'h0, 0, 1, 4'h0, 8'h00);
    add(0, 1, 0, 0, 0, 8'h55, 4'h0, 0, 0, 4'h0, 8'h00);
    // stall: en low for 5 cycles while column 0 is presenting
    add(0, 1, 1, 0, 0, 8'hC0, 4'h0, 1, 0, 4'h0, 8'h00);
    add(0, 1, 0, 0, 0, 8'h55, 4'h0, 1, 0, 4'h0, 8'h00);
    add(0, 1, 0, 0, 0, 8'h55, 4'h0, 1, 0, 4'h0, 8'h00);
    add(0, 1, 0, 0, 0, 8'h55, 4'h1, 1, 0, 4'h1, 8'hC0);
    for (int i = 0; i < 5; i++)
      add(0, 0, 1, 0, 0, 8'h77, 4'h1, 1, 0, 4'h1, 8'hC0);
    add(0, 1, 0, 0, 0, 8'h55, 4'h2, 1, 0, 4'h2, 8'hC0);
    add(0, 1, 0, 0, 0, 8'h55, 4'h4, 1, 0, 4'h4, 8'hC0);
    add(0, 1, 0, 0, 0, 8'h55, 4'h8, 1, 0, 4'h8, 8'hC0);
    add(0, 1, 0, 0, 0, 8'h55, 4'h0, 0, 0, 4'h0, 8'h00);
    // flush with three words in flight, offered word discarded
    add(0, 1, 1, 0, 0, 8'h30, 4'h0, 1, 0, 4'h0, 8'h00);
    add(0, 1, 1, 0, 0, 8'h40, 4'h0, 1, 0, 4'h0, 8'h00);
    add(0, 1, 1, 0, 0, 8'h50, 4'h0, 1, 0, 4'h0, 8'h00);
    add(0, 1, 1, 0, 1, 8'h60, 4'h0, 0, 0, 4'h0, 8'h00);
    add(0, 1, 0, 1, 0, 8'h55, 4'h0, 0, 1, 4'h0, 8'h00);
    for (int i = 0; i < 6; i++)
      add(0, 1, 0, 1, 0, 8'h55, 4'h0, 0, 1, 4'h0, 8'h00);
    // flush while en is low
    add(0, 1, 1, 1, 0, 8'h70, 4'h0, 1, 1, 4'h0, 8'h00);
    add(0, 0, 0, 1, 1, 8'h55, 4'h0, 0, 1, 4'h0, 8'h00);
    for (int i = 0; i < 6; i++)
      add(0, 1, 0, 1, 0, 8'h55, 4'h0, 0, 1, 4'h0, 8'h00);
    // reset mid-flight, priority over en and in_valid
    add(0, 1, 1, 1, 0, 8'h30, 4'h0, 1, 1, 4'h0, 8'h00);
    add(0, 1, 1, 1, 0, 8'h40, 4'h0, 1, 1, 4'h0, 8'h00);
    add(0, 1, 1, 1, 0, 8'h50, 4'h0, 1, 1, 4'h0, 8'h00);
    add(1, 1, 1, 1, 0, 8'h60, 4'h0, 0, 0, 4'hf, 8'h00);
    for (int i = 0; i < 7; i++)
      add(0, 1, 0, 0, 0, 8'h55, 4'h0, 0, 0, 4'h0, 8'h00);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].iv, vecs[i].mode, vecs[i].flush, vecs[i].bin);
      chk("out_valid", i, 32'(out_valid), 32'(vecs[i].ov));
      chk("busy", i, 32'(busy), 32'(vecs[i].bz));
      chk("mode_q", i, 32'(mode_q), 32'(vecs[i].mq));
      for (int c = 0; c < DIM; c++)
        if (vecs[i].bmask[c]) chk($sformatf("Bout[%0d]", c), i, Bout[c], ev(vecs[i].bexp, c));
    end

    // bubble between two valid rows
    step(0, 1, 1, 0, 0, 8'h10);
    step(0, 1, 0, 0, 0, 8'hE0);
    step(0, 1, 1, 0, 0, 8'h20);
    step(0, 1, 0, 0, 0, 8'h55);
    chk("zf_ov_a", 0, 32'(out_valid), 32'h1);
    chk("zf_bout0_a", 0, Bout[0], 32'h10);
    step(0, 1, 0, 0, 0, 8'h55);
    chk("zf_ov_gap", 1, 32'(out_valid), 32'h2);
`ifdef MEM_SKEW_ZERO_FILL_EN
    chk("zf_bout0_gap", 1, Bout[0], 32'h0);
`else
    chk("zf_bout0_gap", 1, Bout[0], 32'hE0);
`endif
    chk("zf_bout1_gap", 1, Bout[1], 32'h11);
    step(0, 1, 0, 0, 0, 8'h55);
    chk("zf_ov_b", 2, 32'(out_valid), 32'h5);
    chk("zf_bout0_b", 2, Bout[0], 32'h20);
    chk("zf_bout2_b", 2, Bout[2], 32'h12);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, 8'h55);
    chk("zf_drained", 3, 32'(busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
